// File: rtl/kernel_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI DCT trace scheduler.
// FRAME_W/SLOTS size the 30-bit packing buffer; CNT_W sizes frame counters.
// Imported by the scheduler top; the arbiter needs nothing from here.
package kernel_oci_dct_pkg;

   localparam int FRAME_W = 6;
   localparam int SLOTS   = 5;
   localparam int BUF_W   = FRAME_W * SLOTS;
   localparam int CNT_W   = 4;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/kernel_oci_dct_rr_arb.sv
// 2-requester arbiter for instruction trace (it) vs data trace (dt).
// Latency: grants are combinational from the requests, enable and pointer.
// Backpressure: no grant while en is low.
// Macro OCI_DCT_ROUND_ROBIN_EN: defined -> 2-way round-robin with a pointer
// register; undefined -> fixed priority, it over dt, no state at all.
// Ports: clk/reset_n (round-robin build only), en, it_req, dt_req, it_gnt, dt_gnt.
module kernel_oci_dct_rr_arb (
`ifdef OCI_DCT_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset_n,
`endif
   input  logic en,
   input  logic it_req,
   input  logic dt_req,
   output logic it_gnt,
   output logic dt_gnt
);

`ifdef OCI_DCT_ROUND_ROBIN_EN
   // ptr_dt = 1 means dt wins the next contested cycle; reset favours it.
   logic ptr_dt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_dt <= 1'b0;
      end else if (en && it_req && dt_req) begin
         // The winner this cycle was the pointed-to side; hand priority over.
         ptr_dt <= ~ptr_dt;
      end
   end

   always_comb begin
      it_gnt = en & it_req & (~dt_req | ~ptr_dt);
      dt_gnt = en & dt_req & (~it_req |  ptr_dt);
   end
`else
   always_comb begin
      it_gnt = en & it_req;
      dt_gnt = en & dt_req & ~it_req;
   end
`endif

endmodule

// File: rtl/kernel_nios2_qsys_0_oci_dct_sched.sv
// Packs it/dt trace frames into a SLOTS-frame buffer and emits full or
// flushed partial words to trace memory. Latency: word valid 1 cycle after
// the filling/flushing accept. Backpressure: readys drop for the whole DRAIN
// state and while trc_on is low; they never depend on tw_ready.
// Ports: clk, reset_n, it_*/dt_* frame inputs with valid/ready, trc_on, flush,
// tw_* output word with valid/ready, dct_buffer/dct_count live buffer view.
// Arbitration policy is chosen by OCI_DCT_ROUND_ROBIN_EN inside the arbiter.
module kernel_nios2_qsys_0_oci_dct_sched
   import kernel_oci_dct_pkg::*;
#(
   parameter int FRAME_W = kernel_oci_dct_pkg::FRAME_W,
   parameter int SLOTS   = kernel_oci_dct_pkg::SLOTS
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         it_valid,
   input  logic [FRAME_W-1:0]           it_frame,
   output logic                         it_ready,
   input  logic                         dt_valid,
   input  logic [FRAME_W-1:0]           dt_frame,
   output logic                         dt_ready,
   input  logic                         trc_on,
   input  logic                         flush,
   output logic                         tw_valid,
   output logic [FRAME_W*SLOTS-1:0]     tw_data,
   output logic [3:0]                   tw_count,
   input  logic                         tw_ready,
   output logic [FRAME_W*SLOTS-1:0]     dct_buffer,
   output logic [3:0]                   dct_count
);

   localparam int BUF_W = FRAME_W * SLOTS;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

   state_t             state, state_nxt;
   logic               trc_on_d;
   logic               arb_en, gnt_it, gnt_dt;
   logic               acc_it, acc_dt, acc;
   logic               flush_cond, emit;
   logic [FRAME_W-1:0] acc_frame;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [BUF_W-1:0]   pack_nxt;

   assign arb_en = (state == FILL) & trc_on;

   kernel_oci_dct_rr_arb u_arb (
`ifdef OCI_DCT_ROUND_ROBIN_EN
      .clk     (clk),
      .reset_n (reset_n),
`endif
      .en      (arb_en),
      .it_req  (it_valid),
      .dt_req  (dt_valid),
      .it_gnt  (gnt_it),
      .dt_gnt  (gnt_dt)
   );

   // Buffer view after this cycle's accept; count includes the accept so a
   // same-cycle flush emits the frame arriving with it.
   always_comb begin
      acc_it     = it_valid & it_ready;
      acc_dt     = dt_valid & dt_ready;
      acc        = acc_it | acc_dt;
      acc_frame  = acc_it ? it_frame : dt_frame;
      cnt_nxt    = dct_count + {{(CNT_W-1){1'b0}}, acc};
      pack_nxt   = dct_buffer;
      if (acc) begin
         pack_nxt[FRAME_W*int'(dct_count) +: FRAME_W] = acc_frame;
      end
      flush_cond = flush | (trc_on_d & ~trc_on);
      emit       = (state == FILL) &
                   ((cnt_nxt == FULL_CNT) | (flush_cond & (cnt_nxt != '0)));
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FILL;
      else          state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (emit)     state_nxt = DRAIN;
         DRAIN:   if (tw_ready) state_nxt = FILL;   // tw_valid is high throughout DRAIN
         default: state_nxt = FILL;
      endcase
   end

   // FSM: outputs (grants are already gated by arb_en)
   always_comb begin
      it_ready = gnt_it;
      dt_ready = gnt_dt;
   end

   // Packing buffer and output word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trc_on_d   <= 1'b0;
         tw_valid   <= 1'b0;
         tw_data    <= '0;
         tw_count   <= '0;
         dct_buffer <= '0;
         dct_count  <= '0;
      end else begin
         trc_on_d <= trc_on;
         if (emit) begin
            tw_data    <= pack_nxt;   // unused slots are still zero
            tw_count   <= cnt_nxt;
            tw_valid   <= 1'b1;
            dct_buffer <= '0;
            dct_count  <= '0;
         end else if (state == FILL) begin
            dct_buffer <= pack_nxt;
            dct_count  <= cnt_nxt;
         end else if (tw_valid && tw_ready) begin
            tw_valid <= 1'b0;
         end
      end
   end

endmodule
